imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Controller for the single-port 64-word instruction memory.
- Shares the memory port between a program loader (writes) and the core fetch unit (reads).
- Sequences boot: the loader fills memory while fetch is held off, then the core is released.
- In run mode, fetch has priority, and a starvation counter guarantees the loader a slot for debug/patch writes.

Parameters:
DEPTH, 64, instruction words in memory
AW, 6, word-index width (log2 DEPTH)
STARVE_LIMIT, 4, consecutive blocked loader cycles before the loader is forced a slot
NOP_WORD, 32'h00000013, word returned on an erroneous fetch (addi x0,x0,0)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-low
load_valid  in  1  loader write request
load_addr  in  32  loader byte address
load_data  in  32  instruction word to write
load_ready  out  1  loader grant; write occurs this cycle
load_err  out  1  registered pulse: last granted write was misaligned/out of range and was dropped
load_done  in  1  loader finished; leave BOOT
reload  in  1  return to BOOT from RUN
fetch_req  in  1  fetch read request
fetch_addr  in  32  fetch byte address (PC)
fetch_gnt  out  1  fetch grant this cycle
fetch_rvalid  out  1  read data valid; one cycle after grant
fetch_rdata  out  32  instruction word
fetch_err  out  1  qualifies fetch_rvalid: misaligned/out-of-range fetch
run  out  1  core enable; 1 only in RUN
mem_en  out  1  memory port enable
mem_we  out  1  memory write enable
mem_addr  out  AW  word index, byte address [AW+1:2]
mem_wdata  out  32  write data
mem_rdata  in  32  memory read data, registered, valid the cycle after mem_en & !mem_we

Behaviour:
- Address check for a byte address A: legal when A[1:0]==0 and A < 4*DEPTH. Word index is A[AW+1:2].
- Reset (rst==0 at posedge):
  - state=BOOT; starve_cnt=0; fetch_rvalid=0; fetch_err=0; load_err=0; pending-read flags cleared.
  - While rst==0, combinational outputs are forced low: load_ready=0, fetch_gnt=0, mem_en=0, mem_we=0, run=0.
  - Memory contents are not touched.
  - Reset mid-transaction discards any pending rvalid.
- State BOOT:
  - fetch_gnt=0 and run=0.
  - load_ready = load_valid.
  - A legal write drives mem_en=1, mem_we=1, mem_addr, mem_wdata=load_data.
  - An illegal write is still granted (load_ready=1) but mem_en=0; load_err=1 next cycle.
  - load_done=1 → RUN next cycle. A write in the same cycle as load_done is still performed.
- State RUN:
  - run=1.
  - Priority: forced loader slot (starve_cnt==STARVE_LIMIT && load_valid) > fetch_req > load_valid.
  - Fetch granted: a legal address drives mem_en=1, mem_we=0. Next cycle fetch_rvalid=1, fetch_rdata=mem_rdata, fetch_err=0.
  - Illegal fetch address: mem_en=0. Next cycle fetch_rvalid=1, fetch_rdata=NOP_WORD, fetch_err=1.
  - Back-to-back grants give one rvalid per cycle, in order.
  - starve_cnt: increments (saturating at STARVE_LIMIT) each cycle load_valid && !load_ready. Clears on any loader grant or when load_valid==0.
  - reload=1 → BOOT next cycle.
    - A fetch granted in the reload cycle still returns its rvalid next cycle.
    - No new fetch is granted once in BOOT.
  - load_done is ignored in RUN.
- At most one of load_ready / fetch_gnt is high per cycle. fetch_rvalid never asserts without a prior fetch_gnt.
- When fetch_rvalid=0: fetch_rdata=0 and fetch_err=0.
- load_err and fetch_err are registered, single-cycle.

Decomposition:
- Shared package imem_pkg:
  - DEPTH/AW/NOP_WORD constants.
  - State encoding: BOOT=1'b0, RUN=1'b1.
  - An addr_legal function used by both loader and fetch checks.
- One natural sub-module: imem_starve_ctr (saturating counter with inc/clr, STARVE_LIMIT parameter, at_limit output).
- Arbitration and response pipeline stay in imem_arbiter.

Test Plan:
- Boot load: rst low 2 cycles; write 32'h00948663 @ 0x2C, then load_done → mem write idx 11 with data 32'h00948663; run=1 the next cycle; fetch_gnt stayed 0 throughout BOOT.
- Fetch latency: in RUN, fetch_req @ 0x04 with memory holding 32'h019806B3 → fetch_gnt same cycle; fetch_rvalid=1, fetch_rdata=32'h019806B3, fetch_err=0 the next cycle. Back-to-back 0x08, 0x0C give consecutive rvalids in order.
- Illegal fetch: fetch_addr=0x102 (misaligned) and 0x100 (out of range) → mem_en=0; rvalid with rdata=32'h00000013, fetch_err=1 for each.
- Starvation: fetch_req held high and load_valid high in RUN → loader blocked exactly 4 cycles; on the 5th cycle load_ready=1, fetch_gnt=0; the following cycle fetch resumes.
- Reload/reset mid-op: fetch granted in the same cycle as reload → rvalid delivered next cycle, then state=BOOT, run=0. rst=0 on a cycle with a pending read → fetch_rvalid=0 next cycle and all grants 0.
- Loader illegal address: write @ 0x101 in BOOT → load_ready=1, mem_en=0, load_err=1 one cycle later; memory unchanged.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared constants, state encoding and address check for the instruction-memory arbiter.
package imem_pkg;

  localparam int unsigned DEPTH        = 64;
  localparam int unsigned AW           = 6;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0013;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A byte address is usable when it is word aligned and falls inside the memory.
  function automatic logic addr_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
  endfunction

endpackage

// File: rtl/imem_starve_ctr.sv
// Saturating count of consecutive cycles the loader has been refused the port.
module imem_starve_ctr
  import imem_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int unsigned CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt;

  // Count blocked cycles, hold at the limit, clear has priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIM)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = (cnt == LIM);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory controller: boot loading, then fetch-priority
// arbitration with a guaranteed loader slot after sustained starvation.
module imem_arbiter
  import imem_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [31:0]   load_addr,
  input  logic [31:0]   load_data,
  output logic          load_ready,
  output logic          load_err,
  input  logic          load_done,
  input  logic          reload,
  input  logic          fetch_req,
  input  logic [31:0]   fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [31:0]   fetch_rdata,
  output logic          fetch_err,
  output logic          run,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t state, state_nxt;
  logic   load_legal, fetch_legal;
  logic   at_limit;
  logic   starve_inc;

  assign load_legal  = addr_legal(load_addr);
  assign fetch_legal = addr_legal(fetch_addr);

  // Loader is starving whenever it asks and is not served this cycle.
  assign starve_inc = load_valid && !load_ready;

  imem_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (!starve_inc),
    .at_limit (at_limit)
  );

  // Next-state, grant selection and memory-port drive.
  always_comb begin
    // NOTE: every output gets a default first so no path through the block can infer a latch.
    state_nxt  = state;
    load_ready = 1'b0;
    fetch_gnt  = 1'b0;
    run        = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;

    if (rst) begin
      unique case (state)
        BOOT: begin
          load_ready = load_valid;
          if (load_done) state_nxt = RUN;
        end
        RUN: begin
          run = 1'b1;
          if (at_limit && load_valid) load_ready = 1'b1;
          else if (fetch_req)         fetch_gnt  = 1'b1;
          else if (load_valid)        load_ready = 1'b1;
          if (reload) state_nxt = BOOT;
        end
        default: state_nxt = BOOT;
      endcase

      // Illegal requests are still granted but never reach the memory.
      if (load_ready && load_legal) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = load_addr[AW+1:2];
        mem_wdata = load_data;
      end else if (fetch_gnt && fetch_legal) begin
        mem_en   = 1'b1;
        mem_addr = fetch_addr[AW+1:2];
      end
    end
  end

  // State register plus the one-cycle response and error pipeline.
  always_ff @(posedge clk) begin
    // NOTE: only control state is reset; the memory array itself is never cleared here.
    if (!rst) begin
      state        <= BOOT;
      fetch_rvalid <= 1'b0;
      fetch_err    <= 1'b0;
      load_err     <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_rvalid <= fetch_gnt;
      fetch_err    <= fetch_gnt && !fetch_legal;
      load_err     <= load_ready && !load_legal;
    end
  end

  assign fetch_rdata = !fetch_rvalid ? 32'h0 :
                       fetch_err     ? NOP_WORD : mem_rdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a cycle-level reference model and a
// behavioural single-port memory behind the DUT.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_valid, load_done, reload, fetch_req;
  logic [31:0] load_addr, load_data, fetch_addr;
  logic        load_ready, load_err, fetch_gnt, fetch_rvalid, fetch_err, run;
  logic [31:0] fetch_rdata, mem_wdata, mem_rdata;
  logic        mem_en, mem_we;
  logic [5:0]  mem_addr;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  imem_arbiter dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_err(load_err), .load_done(load_done),
    .reload(reload),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata), .fetch_err(fetch_err),
    .run(run),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port memory with registered read data.
  logic [31:0] ram [64];
  always @(posedge clk) begin
    if (mem_en && mem_we)  ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata     <= ram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    return ((a % 4) == 0) && (a < 256);
  endfunction

  // Reference model: booted flag, blocked-cycle count, shadow memory, one-deep response.
  bit          m_run = 1'b0;
  int          m_starve = 0;
  logic [31:0] shadow [64];
  logic        e_rvalid = 1'b0, e_ferr = 1'b0, e_lerr = 1'b0;
  logic [31:0] e_rdata = 32'h0;

  always @(negedge clk) begin
    logic        x_lr, x_fg, x_en, x_we, x_run;
    logic [5:0]  x_addr;
    logic [31:0] x_wdata;
    logic        n_rvalid, n_ferr, n_lerr;
    logic [31:0] n_rdata;
    if (mon_en) begin
      check("fetch_rvalid", fetch_rvalid, e_rvalid);
      check("fetch_err",    fetch_err,    e_ferr);
      check("fetch_rdata",  fetch_rdata,  e_rdata);
      check("load_err",     load_err,     e_lerr);

      x_lr = 0; x_fg = 0; x_en = 0; x_we = 0; x_run = 0; x_addr = 0; x_wdata = 0;
      n_rvalid = 0; n_ferr = 0; n_lerr = 0; n_rdata = 0;
      if (rst) begin
        if (!m_run) begin
          x_lr = load_valid;
        end else begin
          x_run = 1;
          if (load_valid && m_starve >= 4) x_lr = 1;
          else if (fetch_req)             x_fg = 1;
          else if (load_valid)            x_lr = 1;
        end
        if (x_lr) begin
          if (legal(load_addr)) begin
            x_en = 1; x_we = 1; x_addr = load_addr[7:2]; x_wdata = load_data;
          end else begin
            n_lerr = 1;
          end
        end
        if (x_fg) begin
          n_rvalid = 1;
          if (legal(fetch_addr)) begin
            x_en = 1; x_addr = fetch_addr[7:2]; n_rdata = shadow[fetch_addr[7:2]];
          end else begin
            n_ferr = 1; n_rdata = 32'h0000_0013;
          end
        end
      end

      check("load_ready", load_ready, x_lr);
      check("fetch_gnt",  fetch_gnt,  x_fg);
      check("run",        run,        x_run);
      check("mem_en",     mem_en,     x_en);
      check("mem_we",     mem_we,     x_we);
      if (x_en)        check("mem_addr",  mem_addr,  x_addr);
      if (x_en && x_we) check("mem_wdata", mem_wdata, x_wdata);

      if (x_en && x_we) shadow[x_addr] = x_wdata;
      if (!rst)                            m_starve = 0;
      else if (load_valid && !x_lr)        m_starve = (m_starve < 4) ? m_starve + 1 : 4;
      else                                 m_starve = 0;
      if (!rst)                            m_run = 0;
      else if (!m_run && load_done)        m_run = 1;
      else if (m_run && reload)            m_run = 0;
      e_rvalid = n_rvalid; e_ferr = n_ferr; e_rdata = n_rdata; e_lerr = n_lerr;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    load_valid = 0; load_addr = 0; load_data = 0; load_done = 0;
    reload = 0; fetch_req = 0; fetch_addr = 0;
  endtask

  // Boot-time write with literal expectations on the memory port.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic done);
    logic [31:0] idx;
    idx = a >> 2;
    load_valid = 1; load_addr = a; load_data = d; load_done = done;
    #2;
    check("boot_load_ready", load_ready, 1);
    check("boot_fetch_gnt",  fetch_gnt,  0);
    check("boot_mem_we",     mem_we,     1);
    check("boot_mem_addr",   mem_addr,   idx);
    check("boot_mem_wdata",  mem_wdata,  d);
    cyc();
    load_valid = 0; load_done = 0;
  endtask

  initial begin
    rst = 0; idle();
    cyc(); mon_en = 1; load_valid = 1;
    #2 check("rst_load_ready", load_ready, 0);
    check("rst_run", run, 0);
    cyc(); check("rst_rvalid", fetch_rvalid, 0);
    rst = 1; idle(); fetch_req = 1; fetch_addr = 32'h04;

    wr(32'h04, 32'h0198_06B3, 0);
    wr(32'h08, 32'h0000_0517, 0);
    wr(32'h0C, 32'h00A0_0093, 0);
    wr(32'h00, 32'h0000_006F, 0);
    load_valid = 1; load_addr = 32'h101; load_data = 32'hDEAD_BEEF;
    #2 check("bad_load_ready", load_ready, 1);
    check("bad_load_mem_en", mem_en, 0);
    cyc(); load_valid = 0;
    check("bad_load_err", load_err, 1);
    wr(32'h2C, 32'h0094_8663, 1);

    check("run_after_done", run, 1);
    #2 check("f04_gnt", fetch_gnt, 1);
    check("f04_mem_addr", mem_addr, 1);
    cyc(); fetch_addr = 32'h08;
    check("f04_rvalid", fetch_rvalid, 1);
    check("f04_rdata", fetch_rdata, 32'h0198_06B3);
    check("f04_err", fetch_err, 0);
    cyc(); fetch_addr = 32'h0C;
    check("f08_rdata", fetch_rdata, 32'h0000_0517);
    cyc(); fetch_addr = 32'h102;
    check("f0C_rdata", fetch_rdata, 32'h00A0_0093);
    #2 check("f102_mem_en", mem_en, 0);
    cyc(); fetch_addr = 32'h100;
    check("f102_rdata", fetch_rdata, 32'h0000_0013);
    check("f102_err", fetch_err, 1);
    #2 check("f100_mem_en", mem_en, 0);
    cyc(); fetch_addr = 32'h00;
    check("f100_rdata", fetch_rdata, 32'h0000_0013);
    check("f100_err", fetch_err, 1);
    cyc(); fetch_req = 0;
    check("f00_unchanged", fetch_rdata, 32'h0000_006F);

    fetch_req = 1; fetch_addr = 32'h04;
    load_valid = 1; load_addr = 32'h14; load_data = 32'hCAFE_F00D;
    for (int i = 0; i < 4; i++) begin
      #2 check("starve_blocked", load_ready, 0);
      check("starve_fetch", fetch_gnt, 1);
      cyc();
    end
    #2 check("forced_load_ready", load_ready, 1);
    check("forced_fetch_gnt", fetch_gnt, 0);
    check("forced_mem_we", mem_we, 1);
    cyc();
    #2 check("resume_fetch", fetch_gnt, 1);
    check("resume_load_ready", load_ready, 0);
    cyc(); load_valid = 0; fetch_addr = 32'h14;
    cyc(); fetch_req = 0;
    check("f14_rdata", fetch_rdata, 32'hCAFE_F00D);

    load_done = 1; load_valid = 1; load_addr = 32'h18; load_data = 32'h1111_1111;
    #2 check("run_load_ready", load_ready, 1);
    cyc(); idle();
    check("done_ignored", run, 1);

    fetch_req = 1; fetch_addr = 32'h08; reload = 1;
    #2 check("reload_gnt", fetch_gnt, 1);
    cyc(); reload = 0;
    check("reload_rvalid", fetch_rvalid, 1);
    check("reload_rdata", fetch_rdata, 32'h0000_0517);
    check("reload_run", run, 0);
    #2 check("reload_no_gnt", fetch_gnt, 0);
    cyc(); fetch_req = 0; load_done = 1;
    cyc(); load_done = 0;
    check("rerun", run, 1);

    fetch_req = 1; fetch_addr = 32'h0C;
    cyc(); rst = 0;
    check("pre_rst_rvalid", fetch_rvalid, 1);
    #2 check("rst_gnt", fetch_gnt, 0);
    cyc();
    check("post_rst_rvalid", fetch_rvalid, 0);
    #2 check("post_rst_gnt", fetch_gnt, 0);
    check("post_rst_load_ready", load_ready, 0);
    rst = 1; idle();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
